// File: rtl/mod_counter_pkg.sv
// ============================================================================
// Module   : mod_counter_pkg
// Purpose  : Shared types and helpers for the modulo counter: count direction
//            and the direction-dependent terminal and start values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_counter_pkg;

  // Helpers work at a fixed maximum width; callers size-cast in and out.
  localparam int MC_MAXW = 32;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Value at which the counter wraps: top when counting up, zero when down.
  function automatic logic [MC_MAXW-1:0] terminal_value(input dir_e d,
                                                        input logic [MC_MAXW-1:0] top);
    return (d == DIR_UP) ? top : '0;
  endfunction

  // Value the counter restarts from: zero when counting up, top when down.
  function automatic logic [MC_MAXW-1:0] start_value(input dir_e d,
                                                     input logic [MC_MAXW-1:0] top);
    return (d == DIR_UP) ? '0 : top;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_counter_top.sv
// ============================================================================
// Module   : mod_counter_top
// Purpose  : Terminal-value holder. A write lands in a shadow register and
//            only becomes active on a commit strobe, so the active terminal
//            never changes mid-period.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter_top
  import mod_counter_pkg::*;
#(
  parameter int W       = 8,
  parameter int DEF_TOP = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         top_wr_i,
  input  logic [W-1:0] top_val_i,
  input  logic         commit_i,
  output logic [W-1:0] top_q_o,
  output logic [W-1:0] top_d_o
);

  logic [W-1:0] top_q, top_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic         pend_q, pend_d;

  // Commit picks a same-cycle write over the shadow; otherwise a write only
  // refreshes the shadow and marks it pending.
  always_comb begin
    top_d    = top_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (commit_i) begin
      pend_d = 1'b0;
      if (top_wr_i) begin
        top_d = top_val_i;
      end else if (pend_q) begin
        top_d = shadow_q;
      end
    end else if (top_wr_i) begin
      shadow_d = top_val_i;
      pend_d   = 1'b1;
    end
  end

  // Active/shadow/pending registers; reset discards any pending value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q    <= W'(DEF_TOP);
      shadow_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      top_q    <= top_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
    end
  end

  assign top_q_o = top_q;
  assign top_d_o = top_d;

endmodule

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
// Module   : mod_counter
// Purpose  : Runtime-programmable modulo counter with up/down count, load,
//            clear, deferred terminal update and registered terminal flag.
//            Optional mid-point flag enabled by defining MOD_COUNTER_HALF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int W       = 8,
  parameter int DEF_TOP = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dir,
  input  logic         top_wr,
  input  logic [W-1:0] top_val,
  output logic [W-1:0] q,
  output logic [W-1:0] top_q,
  output logic         ov,
  output logic         wrap,
  output logic         half
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         ov_q, ov_d;
  logic         wrap_q, wrap_d;
  logic [W-1:0] w_top_d;
  logic [W-1:0] w_term_cur;
  logic [W-1:0] w_load_clamped;
  logic         w_wrap_step;
  logic         w_commit;
  dir_e         w_dir;

  assign w_dir = dir_e'(dir);

  // The wrap decision looks at the terminal for the dir sampled this cycle
  // (identical to ov when dir is steady) so a same-cycle dir flip can never
  // step out of range. A count stranded above a shrunken top also wraps.
  assign w_term_cur  = W'(terminal_value(w_dir, MC_MAXW'(top_q)));
  assign w_wrap_step = ce & ~clr & ~load &
                       ((cnt_q == w_term_cur) | (cnt_q > top_q));
  assign w_commit    = clr | w_wrap_step;
  assign w_load_clamped = (load_val > top_q) ? top_q : load_val;

  mod_counter_top #(
    .W       (W),
    .DEF_TOP (DEF_TOP)
  ) u_top (
    .clk       (clk),
    .rst       (rst),
    .top_wr_i  (top_wr),
    .top_val_i (top_val),
    .commit_i  (w_commit),
    .top_q_o   (top_q),
    .top_d_o   (w_top_d)
  );

  // Priority mux: clear, then load, then step, then hold; flags follow next q.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = W'(start_value(w_dir, MC_MAXW'(w_top_d)));
    end else if (load) begin
      cnt_d = w_load_clamped;
    end else if (ce) begin
      if (w_wrap_step) begin
        cnt_d = W'(start_value(w_dir, MC_MAXW'(w_top_d)));
      end else if (w_dir == DIR_UP) begin
        cnt_d = cnt_q + W'(1);
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end
    ov_d   = (cnt_d == W'(terminal_value(w_dir, MC_MAXW'(w_top_d))));
    wrap_d = w_wrap_step;
  end

  // Count and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      ov_q   <= (DEF_TOP == 0);
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ov_q   <= ov_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef MOD_COUNTER_HALF_EN
  logic half_q, half_d;

  // Mid-point flag, same next-state timing as ov.
  always_comb begin
    half_d = (cnt_d == (w_top_d >> 1));
  end

  // Mid-point flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q <= 1'b0;
    end else begin
      half_q <= half_d;
    end
  end

  assign half = half_q;
`else
  assign half = 1'b0;
`endif

  assign q    = cnt_q;
  assign ov   = ov_q;
  assign wrap = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ============================================================================
// Module   : tb_mod_counter
// Purpose  : Self-checking bench for mod_counter: a behavioural reference
//            model compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_counter;

  localparam int W       = 8;
  localparam int DEF_TOP = 24;
`ifdef MOD_COUNTER_HALF_EN
  localparam bit HALF_EN = 1'b1;
`else
  localparam bit HALF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ce = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b0, top_wr = 1'b0;
  logic [W-1:0] load_val = '0, top_val = '0;
  logic [W-1:0] q, top_q;
  logic         ov, wrap, half;

  int n_checks = 0;
  int n_fail   = 0;

  mod_counter #(.W(W), .DEF_TOP(DEF_TOP)) dut (
    .clk(clk), .rst(rst), .ce(ce), .clr(clr), .load(load),
    .load_val(load_val), .dir(dir), .top_wr(top_wr), .top_val(top_val),
    .q(q), .top_q(top_q), .ov(ov), .wrap(wrap), .half(half)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic straight from the counter's rules.
  int m_q, m_top, m_shadow;
  bit m_pend, m_ov, m_wrap, m_half;

  always @(posedge clk or posedge rst) begin
    int  term, nq, ntop;
    bit  wstep;
    if (rst) begin
      m_q = 0; m_top = DEF_TOP; m_shadow = 0; m_pend = 0;
      m_ov = (DEF_TOP == 0); m_wrap = 0; m_half = 0;
    end else begin
      term  = dir ? 0 : m_top;
      wstep = ce && !clr && !load && (m_q == term || m_q > m_top);
      ntop  = m_top;
      if (clr || wstep) begin
        if (top_wr) ntop = int'(top_val);
        else if (m_pend) ntop = m_shadow;
        m_pend = 0;
      end else if (top_wr) begin
        m_shadow = int'(top_val);
        m_pend   = 1;
      end
      if (clr)       nq = dir ? ntop : 0;
      else if (load) nq = (int'(load_val) < m_top) ? int'(load_val) : m_top;
      else if (ce)   nq = wstep ? (dir ? ntop : 0) : (dir ? m_q - 1 : m_q + 1);
      else           nq = m_q;
      m_ov   = (nq == (dir ? 0 : ntop));
      m_wrap = wstep;
      m_half = HALF_EN && (nq == ntop / 2);
      m_q    = nq;
      m_top  = ntop;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("cmp_q",     int'(q),     m_q);
      check("cmp_top",   int'(top_q), m_top);
      check("cmp_ov",    int'(ov),    int'(m_ov));
      check("cmp_wrap",  int'(wrap),  int'(m_wrap));
      check("cmp_half",  int'(half),  int'(m_half));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    cyc(1);
    check("rst_q", int'(q), 0);
    check("rst_top", int'(top_q), 24);
    check("rst_ov", int'(ov), 0);
    check("rst_wrap", int'(wrap), 0);
    rst = 1'b0;
    ce  = 1'b1;

    // Up count with default top: 0..24, ov at 24, wrap with q=0
    cyc(24);
    check("up_q24", int'(q), 24);
    check("up_ov24", int'(ov), 1);
    cyc(1);
    check("up_wrapq", int'(q), 0);
    check("up_wrap", int'(wrap), 1);
    check("up_ov0", int'(ov), 0);

    // Pending top written at q=5 only takes effect at the wrap
    cyc(5);
    top_wr = 1'b1; top_val = 8'd9;
    cyc(1);
    top_wr = 1'b0;
    check("pend_q6", int'(q), 6);
    check("pend_top", int'(top_q), 24);
    cyc(18);
    check("pend_q24", int'(q), 24);
    check("pend_top24", int'(top_q), 24);
    cyc(1);
    check("commit_top", int'(top_q), 9);
    check("commit_q", int'(q), 0);
    cyc(9);
    check("mod10_q9", int'(q), 9);
    check("mod10_ov", int'(ov), 1);
    cyc(1);
    check("mod10_wrap", int'(wrap), 1);

    // Down count: from q=0 the flip wraps straight to 9
    dir = 1'b1;
    cyc(1);
    check("dn_q9", int'(q), 9);
    check("dn_wrap", int'(wrap), 1);
    cyc(9);
    check("dn_q0", int'(q), 0);
    check("dn_ov", int'(ov), 1);
    cyc(1);
    check("dn_reload", int'(q), 9);
    cyc(3);
    check("dn_q6", int'(q), 6);
    dir = 1'b0;
    cyc(1);
    check("toggle_q7", int'(q), 7);

    // Priority: clr beats load and ce
    clr = 1'b1; load = 1'b1; load_val = 8'd3;
    cyc(1);
    check("prio_q", int'(q), 0);
    clr = 1'b0; load_val = 8'd200;
    cyc(1);
    check("clamp_q", int'(q), 9);
    check("clamp_ov", int'(ov), 1);
    load = 1'b0;

    // top = 0 committed directly by a same-cycle clear
    top_wr = 1'b1; top_val = 8'd0; clr = 1'b1;
    cyc(1);
    top_wr = 1'b0; clr = 1'b0;
    check("top0_top", int'(top_q), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("top0_q", int'(q), 0);
      check("top0_ov", int'(ov), 1);
      check("top0_wrap", int'(wrap), 1);
    end
    ce = 1'b0;
    cyc(2);
    check("top0_nowrap", int'(wrap), 0);

    // Back to top 9, mid-point check at q=4
    ce = 1'b1; top_wr = 1'b1; top_val = 8'd9; clr = 1'b1;
    cyc(1);
    top_wr = 1'b0; clr = 1'b0;
    cyc(4);
    check("half_q4", int'(q), 4);
    check("half_flag", int'(half), HALF_EN ? 1 : 0);

    // Reset mid-count with a top pending: pending value is discarded
    cyc(3);
    top_wr = 1'b1; top_val = 8'd3;
    cyc(1);
    top_wr = 1'b0;
    check("prerst_q8", int'(q), 8);
    #2 rst = 1'b1;
    #1;
    check("arst_q", int'(q), 0);
    check("arst_top", int'(top_q), 24);
    check("arst_ov", int'(ov), 0);
    check("arst_wrap", int'(wrap), 0);
    cyc(1);
    rst = 1'b0;
    cyc(25);
    check("post_top", int'(top_q), 24);
    check("post_wrap", int'(wrap), 1);
    check("post_q", int'(q), 0);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
